// File: rtl/ext_intr_ctrl_pkg.sv
// Shared types and constants for the external interrupt controller.
package ext_intr_ctrl_pkg;

    localparam int unsigned ICR_DATA_W    = 32;
    localparam int unsigned ICR_ADDR_W    = 3;
    localparam int unsigned ICR_ID_W      = 4;
    localparam int unsigned ICR_CAUSE_W   = 31;
    localparam int unsigned ICR_CAUSE_OFS = 16;

    localparam logic [ICR_ADDR_W-1:0] ICR_PENDING  = 3'd0;
    localparam logic [ICR_ADDR_W-1:0] ICR_ENABLE   = 3'd1;
    localparam logic [ICR_ADDR_W-1:0] ICR_EDGE     = 3'd2;
    localparam logic [ICR_ADDR_W-1:0] ICR_CLAIM    = 3'd3;
    localparam logic [ICR_ADDR_W-1:0] ICR_COMPLETE = 3'd4;

    typedef enum logic [1:0] {
        ICR_IDLE    = 2'd0,
        ICR_REQ     = 2'd1,
        ICR_SERVICE = 2'd2
    } icr_state_e;

endpackage

// File: rtl/ext_intr_ctrl_if.sv
// Register bus between firmware-facing master and the interrupt controller.
interface ext_intr_ctrl_if;

    logic                                        wr;
    logic [ext_intr_ctrl_pkg::ICR_ADDR_W-1:0]    addr;
    logic [ext_intr_ctrl_pkg::ICR_DATA_W-1:0]    wdata;
    logic [ext_intr_ctrl_pkg::ICR_DATA_W-1:0]    rdata;

    modport master (output wr, output addr, output wdata, input  rdata);
    modport slave  (input  wr, input  addr, input  wdata, output rdata);

endinterface

// File: rtl/ext_intr_ctrl_sync_2ff.sv
// Two-flop synchroniser for lines asynchronous to clk_i.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= '0;
            q_o  <= '0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/ext_intr_ctrl.sv
// External interrupt controller: synchronise, latch pending, fixed-priority
// arbitrate, request to the CSR unit and track claim/complete.
module ext_intr_ctrl
    import ext_intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 8,
    parameter int unsigned CAUSE_OFS = ICR_CAUSE_OFS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SRC-1:0]     src_i,
    ext_intr_ctrl_if.slave         bus,
    input  logic                   int_ack_i,
    output logic                   m_ext_intr_o,
    output logic [ICR_CAUSE_W-1:0] mcause_o
);

    logic [NUM_SRC-1:0]  sync;
    logic [NUM_SRC-1:0]  sync_q;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  pend_q;
    logic [NUM_SRC-1:0]  enable_q;
    logic [NUM_SRC-1:0]  edge_q;
    logic [NUM_SRC-1:0]  id_mask;
    logic [NUM_SRC-1:0]  claim_mask;
    logic [NUM_SRC-1:0]  isr_mask;
    logic [NUM_SRC-1:0]  eligible;
    logic [ICR_ID_W-1:0] id_q;
    logic [ICR_ID_W-1:0] win_id;
    logic                win_vld;
    logic                id_elig;
    logic                claim;
    logic                complete_hit;
    icr_state_e          state_q;
    logic                unused_wdata;

    sync_2ff #(.WIDTH(NUM_SRC)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (src_i),
        .q_o   (sync)
    );

    assign rise         = sync & ~sync_q;
    assign id_mask      = NUM_SRC'(1) << id_q;
    assign claim        = (state_q == ICR_REQ) && int_ack_i;
    assign claim_mask   = claim ? id_mask : '0;
    assign isr_mask     = (state_q == ICR_SERVICE) ? id_mask : '0;
    assign eligible     = pend_q & enable_q & ~isr_mask;
    assign id_elig      = |(eligible & id_mask);
    assign complete_hit = bus.wr && (bus.addr == ICR_COMPLETE)
                          && (bus.wdata[ICR_ID_W-1:0] == id_q);
    assign unused_wdata = &{1'b0, bus.wdata[ICR_DATA_W-1:NUM_SRC]};

    // Edge sources: a new rise wins over a same-cycle claim. Level sources follow sync.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            pend_q <= '0;
        end else begin
            sync_q <= sync;
            pend_q <= (edge_q & ((pend_q & ~claim_mask) | rise)) | (~edge_q & sync);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q <= '0;
            edge_q   <= '0;
        end else if (bus.wr) begin
            if (bus.addr == ICR_ENABLE) enable_q <= bus.wdata[NUM_SRC-1:0];
            if (bus.addr == ICR_EDGE)   edge_q   <= bus.wdata[NUM_SRC-1:0];
        end
    end

    // Lowest eligible index wins.
    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id  = ICR_ID_W'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ICR_IDLE;
            id_q         <= '0;
            m_ext_intr_o <= 1'b0;
            mcause_o     <= '0;
        end else begin
            case (state_q)
                ICR_IDLE: begin
                    if (win_vld) begin
                        state_q      <= ICR_REQ;
                        id_q         <= win_id;
                        mcause_o     <= ICR_CAUSE_W'(CAUSE_OFS) + ICR_CAUSE_W'(win_id);
                        m_ext_intr_o <= 1'b1;
                    end
                end
                ICR_REQ: begin
                    if (int_ack_i) begin
                        state_q      <= ICR_SERVICE;
                        m_ext_intr_o <= 1'b0;
                    end else if (!id_elig) begin
                        state_q      <= ICR_IDLE;
                        m_ext_intr_o <= 1'b0;
                    end
                end
                ICR_SERVICE: begin
                    if (complete_hit) state_q <= ICR_IDLE;
                end
                default: begin
                    state_q      <= ICR_IDLE;
                    m_ext_intr_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ICR_PENDING: bus.rdata = ICR_DATA_W'(pend_q);
            ICR_ENABLE:  bus.rdata = ICR_DATA_W'(enable_q);
            ICR_EDGE:    bus.rdata = ICR_DATA_W'(edge_q);
            ICR_CLAIM:   bus.rdata = {(state_q == ICR_SERVICE), 27'b0, id_q};
            default:     bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Directed bench for ext_intr_ctrl with hand-computed expectations.
module tb_ext_intr_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  src_i;
    logic        int_ack_i;
    logic        m_ext_intr_o;
    logic [30:0] mcause_o;
    int          total;
    int          bad;

    ext_intr_ctrl_if bus ();

    ext_intr_ctrl #(.NUM_SRC(8), .CAUSE_OFS(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .src_i        (src_i),
        .bus          (bus),
        .int_ack_i    (int_ack_i),
        .m_ext_intr_o (m_ext_intr_o),
        .mcause_o     (mcause_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick(1);
        bus.wr    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic ack_pulse();
        int_ack_i = 1'b1;
        tick(1);
        int_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #2;
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", m_ext_intr_o); end
        total++; if (mcause_o !== 31'd0) begin bad++; $display("FAIL reset_cause got=%0d want=0", mcause_o); end
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_claim got=%h want=0", rd); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        tick(1);
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read(3'd1, rd);
        total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL enable_width got=%h want=000000ff", rd); end
        bus_write(3'd2, 32'hA5A5_0F3C);
        bus_read(3'd2, rd);
        total++; if (rd !== 32'h0000_003C) begin bad++; $display("FAIL edge_rw got=%h want=0000003c", rd); end
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd7, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h want=0", rd); end
        bus_read(3'd4, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL complete_read got=%h want=0", rd); end
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h0);
    endtask

    task automatic test_edge_single();
        logic [31:0] rd;
        bus_write(3'd1, 32'h04);
        bus_write(3'd2, 32'h04);
        src_i = 8'h04;
        tick(3);
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL edge_early got=%b want=0", m_ext_intr_o); end
        tick(1);
        total++; if (m_ext_intr_o !== 1'b1) begin bad++; $display("FAIL edge_req got=%b want=1", m_ext_intr_o); end
        total++; if (mcause_o !== 31'd18) begin bad++; $display("FAIL edge_cause got=%0d want=18", mcause_o); end
        src_i = 8'h00;
        ack_pulse();
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h8000_0002) begin bad++; $display("FAIL edge_claim got=%h want=80000002", rd); end
        bus_read(3'd0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL edge_pend_clr got=%h want=0", rd); end
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL edge_svc_req got=%b want=0", m_ext_intr_o); end
        bus_write(3'd4, 32'h2);
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h0000_0002) begin bad++; $display("FAIL edge_complete got=%h want=00000002", rd); end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        bus_write(3'd1, 32'h22);
        bus_write(3'd2, 32'h22);
        src_i = 8'h22;
        tick(4);
        total++; if (m_ext_intr_o !== 1'b1) begin bad++; $display("FAIL prio_req got=%b want=1", m_ext_intr_o); end
        total++; if (mcause_o !== 31'd17) begin bad++; $display("FAIL prio_first got=%0d want=17", mcause_o); end
        ack_pulse();
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h8000_0001) begin bad++; $display("FAIL prio_claim got=%h want=80000001", rd); end
        bus_write(3'd4, 32'h1);
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL prio_gap got=%b want=0", m_ext_intr_o); end
        tick(1);
        total++; if (m_ext_intr_o !== 1'b1) begin bad++; $display("FAIL prio_second_req got=%b want=1", m_ext_intr_o); end
        total++; if (mcause_o !== 31'd21) begin bad++; $display("FAIL prio_second got=%0d want=21", mcause_o); end
        ack_pulse();
        bus_write(3'd4, 32'h5);
        src_i = 8'h00;
    endtask

    task automatic test_level();
        logic [31:0] rd;
        bus_write(3'd1, 32'h08);
        bus_write(3'd2, 32'h00);
        src_i = 8'h08;
        tick(4);
        total++; if (m_ext_intr_o !== 1'b1) begin bad++; $display("FAIL lvl_req got=%b want=1", m_ext_intr_o); end
        total++; if (mcause_o !== 31'd19) begin bad++; $display("FAIL lvl_cause got=%0d want=19", mcause_o); end
        ack_pulse();
        bus_read(3'd0, rd);
        total++; if (rd !== 32'h08) begin bad++; $display("FAIL lvl_pend_kept got=%h want=08", rd); end
        bus_write(3'd4, 32'h3);
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL lvl_gap got=%b want=0", m_ext_intr_o); end
        tick(1);
        total++; if (m_ext_intr_o !== 1'b1) begin bad++; $display("FAIL lvl_rereq got=%b want=1", m_ext_intr_o); end
        ack_pulse();
        src_i = 8'h00;
        tick(3);
        bus_read(3'd0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL lvl_pend_drop got=%h want=0", rd); end
        bus_write(3'd4, 32'h3);
        tick(2);
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL lvl_stay_idle got=%b want=0", m_ext_intr_o); end
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h0000_0003) begin bad++; $display("FAIL lvl_claim got=%h want=00000003", rd); end
    endtask

    task automatic test_withdraw();
        logic [31:0] rd;
        bus_write(3'd2, 32'h10);
        bus_write(3'd1, 32'h10);
        src_i = 8'h10;
        tick(4);
        total++; if (mcause_o !== 31'd20) begin bad++; $display("FAIL wd_cause got=%0d want=20", mcause_o); end
        bus_write(3'd1, 32'h00);
        total++; if (m_ext_intr_o !== 1'b1) begin bad++; $display("FAIL wd_hold got=%b want=1", m_ext_intr_o); end
        tick(1);
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL wd_drop got=%b want=0", m_ext_intr_o); end
        ack_pulse();
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL wd_late_ack got=%b want=0", m_ext_intr_o); end
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h0000_0004) begin bad++; $display("FAIL wd_claim got=%h want=00000004", rd); end
        bus_read(3'd0, rd);
        total++; if (rd !== 32'h10) begin bad++; $display("FAIL wd_pend got=%h want=10", rd); end
        src_i = 8'h00;
        tick(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bus_write(3'd2, 32'h40);
        bus_write(3'd1, 32'h40);
        src_i = 8'h40;
        tick(4);
        total++; if (mcause_o !== 31'd22) begin bad++; $display("FAIL b2b_cause got=%0d want=22", mcause_o); end
        ack_pulse();
        bus_write(3'd4, 32'h5);
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h8000_0006) begin bad++; $display("FAIL b2b_wrong_id got=%h want=80000006", rd); end
        src_i = 8'h00;
        tick(3);
        src_i = 8'h40;
        tick(3);
        bus_read(3'd0, rd);
        total++; if (rd !== 32'h40) begin bad++; $display("FAIL b2b_pend got=%h want=40", rd); end
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL b2b_svc_req got=%b want=0", m_ext_intr_o); end
        bus_write(3'd4, 32'h6);
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", m_ext_intr_o); end
        tick(1);
        total++; if (m_ext_intr_o !== 1'b1) begin bad++; $display("FAIL b2b_rereq got=%b want=1", m_ext_intr_o); end
        total++; if (mcause_o !== 31'd22) begin bad++; $display("FAIL b2b_recause got=%0d want=22", mcause_o); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        #2;
        rst_i = 1'b1;
        src_i = 8'h00;
        #1;
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL ar_req got=%b want=0", m_ext_intr_o); end
        total++; if (mcause_o !== 31'd0) begin bad++; $display("FAIL ar_cause got=%0d want=0", mcause_o); end
        bus_read(3'd0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL ar_pend got=%h want=0", rd); end
        bus_read(3'd1, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL ar_enable got=%h want=0", rd); end
        tick(1);
        bus_read(3'd2, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL ar_edge got=%h want=0", rd); end
        bus_read(3'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL ar_claim got=%h want=0", rd); end
        tick(1);
        rst_i = 1'b0;
        tick(3);
        total++; if (m_ext_intr_o !== 1'b0) begin bad++; $display("FAIL ar_after got=%b want=0", m_ext_intr_o); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_i     = 1'b1;
        src_i     = 8'h00;
        int_ack_i = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 3'd0;
        bus.wdata = 32'h0;
        test_reset();
        test_regs();
        test_edge_single();
        test_priority();
        test_level();
        test_withdraw();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
